// File: rtl/c2f_req_sched_if.sv
// Shared types and the core/ring signal bundle for the C2F remote request scheduler.
package c2f_req_sched_pkg;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} t_opcode;
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT_RSP, S_DONE} t_slot_state;
endpackage

interface c2f_req_sched_if;
  import c2f_req_sched_pkg::*;

  // Core memory stage (Q103H)
  logic [3:0]  ThreadQ103H;
  logic [31:0] AddressQ103H;
  logic [31:0] WrDataQ103H;
  logic        RdEnQ103H;
  logic        WrEnQ103H;
  logic        RemoteQ103H;
  // Ring response side
  logic        C2F_RspStall;
  logic        C2F_RspValidQ502H;
  logic [1:0]  C2F_RspThreadIDQ502H;
  logic [31:0] C2F_RspDataQ502H;
  // Ring request side
  logic        C2F_ReqValidQ500H;
  t_opcode     C2F_ReqOpcodeQ500H;
  logic [1:0]  C2F_ReqThreadIDQ500H;
  logic [31:0] C2F_ReqAddressQ500H;
  logic [31:0] C2F_ReqDataQ500H;
  // Back to core
  logic [3:0]  ThreadFreeze;
  logic        C2F_RspMatchQ104H;
  logic [31:0] C2F_RspDataQ104H;
  logic [3:0]  TimeoutErr;
  logic        SpurRspErr;

  // Scheduler side
  modport slave (
    input  ThreadQ103H, AddressQ103H, WrDataQ103H, RdEnQ103H, WrEnQ103H, RemoteQ103H,
    input  C2F_RspStall, C2F_RspValidQ502H, C2F_RspThreadIDQ502H, C2F_RspDataQ502H,
    output C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
    output C2F_ReqAddressQ500H, C2F_ReqDataQ500H,
    output ThreadFreeze, C2F_RspMatchQ104H, C2F_RspDataQ104H, TimeoutErr, SpurRspErr
  );

  // Core/ring side
  modport master (
    output ThreadQ103H, AddressQ103H, WrDataQ103H, RdEnQ103H, WrEnQ103H, RemoteQ103H,
    output C2F_RspStall, C2F_RspValidQ502H, C2F_RspThreadIDQ502H, C2F_RspDataQ502H,
    input  C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
    input  C2F_ReqAddressQ500H, C2F_ReqDataQ500H,
    input  ThreadFreeze, C2F_RspMatchQ104H, C2F_RspDataQ104H, TimeoutErr, SpurRspErr
  );
endinterface

// File: rtl/c2f_req_sched.sv
// Per-thread remote load/store scheduler: captures remote accesses, round-robins them
// onto the C2F ring request port, tracks read responses with timeout, and replays
// read data to the core on the owning thread's next memory-stage slot.
module c2f_req_sched
  import c2f_req_sched_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] TO_DATA     = 32'hDEAD_BEEF,
  parameter int          CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input logic             QClk,
  input logic             RstQnnnH,
  c2f_req_sched_if.slave  bus
);

  logic [3:0]  capture;
  logic [3:0]  rsp_hit;
  logic [3:0]  idle_v;
  logic [3:0]  pend_v;
  logic [3:0]  wait_v;
  logic [3:0]  done_v;
  logic [3:0]  tout_v;
  logic [3:0]  grant;
  logic [3:0]  replay;
  t_opcode     slot_op   [4];
  logic [31:0] slot_addr [4];
  logic [31:0] slot_data [4];

  logic        grant_any;
  logic [1:0]  grant_id;
  logic [1:0]  arb_idx;
  logic [1:0]  rr_q, rr_d;
  logic        spur_q, spur_d;
  logic [31:0] replay_data;

  logic        req_valid_q;
  t_opcode     req_op_q;
  logic [1:0]  req_tid_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_data_q;
  logic        rsp_match_q;
  logic [31:0] rsp_data_q;

  logic        access;
  assign access = (bus.RdEnQ103H | bus.WrEnQ103H) & bus.RemoteQ103H;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_slot
      t_slot_state      state_q, state_d;
      t_opcode          op_q, op_d;
      logic [31:0]      addr_q, addr_d;
      logic [31:0]      data_q, data_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             tout_q, tout_d;

      assign capture[gi] = bus.ThreadQ103H[gi] & access;
      assign rsp_hit[gi] = bus.C2F_RspValidQ502H && (bus.C2F_RspThreadIDQ502H == 2'(gi));

      // Slot next state: capture, grant, response/timeout, and replay consumption.
      always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        tout_d  = tout_q;
        unique case (state_q)
          S_IDLE: begin
            if (capture[gi]) begin
              state_d = S_PEND;
              op_d    = bus.WrEnQ103H ? OP_WR : OP_RD;
              addr_d  = bus.AddressQ103H;
              data_d  = bus.WrDataQ103H;
            end
          end
          S_PEND: begin
            if (grant[gi]) begin
              if (op_q == OP_RD) begin
                state_d = S_WAIT_RSP;
                cnt_d   = '0;
              end else begin
                state_d = S_IDLE;  // stores are posted
              end
            end
          end
          S_WAIT_RSP: begin
            // A real response beats expiry in the same cycle.
            if (rsp_hit[gi]) begin
              state_d = S_DONE;
              data_d  = bus.C2F_RspDataQ502H;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
              state_d = S_DONE;
              data_d  = TO_DATA;
              tout_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_DONE: begin
            if (bus.ThreadQ103H[gi]) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end

      // Slot state register.
      always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
          state_q <= S_IDLE;
          op_q    <= OP_RD;
          addr_q  <= '0;
          data_q  <= '0;
          cnt_q   <= '0;
          tout_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          op_q    <= op_d;
          addr_q  <= addr_d;
          data_q  <= data_d;
          cnt_q   <= cnt_d;
          tout_q  <= tout_d;
        end
      end

      assign idle_v[gi]    = (state_q == S_IDLE);
      assign pend_v[gi]    = (state_q == S_PEND);
      assign wait_v[gi]    = (state_q == S_WAIT_RSP);
      assign done_v[gi]    = (state_q == S_DONE);
      assign tout_v[gi]    = tout_q;
      assign slot_op[gi]   = op_q;
      assign slot_addr[gi] = addr_q;
      assign slot_data[gi] = data_q;
    end
  endgenerate

  // Round-robin pick of the first pending slot at/after the pointer, unless the ring stalls.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = rr_q;
    arb_idx   = rr_q;
    if (!bus.C2F_RspStall) begin
      for (int off = 0; off < 4; off++) begin
        arb_idx = rr_q + 2'(off);
        if (!grant_any && pend_v[arb_idx]) begin
          grant_any = 1'b1;
          grant_id  = arb_idx;
        end
      end
    end
    grant = grant_any ? (4'b0001 << grant_id) : 4'b0000;
    rr_d  = grant_any ? grant_id + 2'd1 : rr_q;
  end

  // A response for a thread that is not waiting is dropped and flagged.
  always_comb begin
    spur_d = spur_q;
    if (bus.C2F_RspValidQ502H && !wait_v[bus.C2F_RspThreadIDQ502H]) spur_d = 1'b1;
  end

  // Completed read data is handed back on the owning thread's next slot.
  always_comb begin
    replay      = done_v & bus.ThreadQ103H;
    replay_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (replay[i]) replay_data = replay_data | slot_data[i];
    end
  end

  // Registered ring request, replay output, pointer and sticky spurious flag.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      rr_q        <= '0;
      spur_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_op_q    <= OP_RD;
      req_tid_q   <= '0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      rsp_match_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      spur_q      <= spur_d;
      req_valid_q <= grant_any;
      req_op_q    <= grant_any ? slot_op[grant_id]   : OP_RD;
      req_tid_q   <= grant_any ? grant_id            : 2'd0;
      req_addr_q  <= grant_any ? slot_addr[grant_id] : 32'd0;
      req_data_q  <= grant_any ? slot_data[grant_id] : 32'd0;
      rsp_match_q <= |replay;
      rsp_data_q  <= replay_data;
    end
  end

  // A thread issuing a new remote access while its request is still in flight is illegal.
  always_ff @(posedge QClk) begin
    if (!RstQnnnH) assert (!(|(capture & (pend_v | wait_v))));
  end

  assign bus.C2F_ReqValidQ500H    = req_valid_q;
  assign bus.C2F_ReqOpcodeQ500H   = req_op_q;
  assign bus.C2F_ReqThreadIDQ500H = req_tid_q;
  assign bus.C2F_ReqAddressQ500H  = req_addr_q;
  assign bus.C2F_ReqDataQ500H     = req_data_q;
  // Freeze covers the capture cycle itself so the core stalls immediately.
  assign bus.ThreadFreeze         = RstQnnnH ? 4'b0000 : (pend_v | wait_v | (capture & idle_v));
  assign bus.C2F_RspMatchQ104H    = rsp_match_q;
  assign bus.C2F_RspDataQ104H     = rsp_data_q;
  assign bus.TimeoutErr           = tout_v;
  assign bus.SpurRspErr           = spur_q;

endmodule

// File: tb/tb_c2f_req_sched.sv
// Directed testbench for c2f_req_sched.
module tb_c2f_req_sched;
  import c2f_req_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  c2f_req_sched_if bus ();

  c2f_req_sched dut (
    .QClk     (clk),
    .RstQnnnH (rst),
    .bus      (bus)
  );

  // One line per issued ring request.
  always @(negedge clk) begin
    if (bus.C2F_ReqValidQ500H)
      $display("req op=%s tid=%0d addr=%08h data=%08h", bus.C2F_ReqOpcodeQ500H.name(),
               bus.C2F_ReqThreadIDQ500H, bus.C2F_ReqAddressQ500H, bus.C2F_ReqDataQ500H);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_core();
    bus.ThreadQ103H  = 4'b0;
    bus.AddressQ103H = 32'h0;
    bus.WrDataQ103H  = 32'h0;
    bus.RdEnQ103H    = 1'b0;
    bus.WrEnQ103H    = 1'b0;
    bus.RemoteQ103H  = 1'b0;
  endtask

  task automatic clear_rsp();
    bus.C2F_RspValidQ502H    = 1'b0;
    bus.C2F_RspThreadIDQ502H = 2'd0;
    bus.C2F_RspDataQ502H     = 32'h0;
  endtask

  task automatic drive_access(input logic [3:0] th, input logic [31:0] addr,
                              input logic [31:0] wd, input logic rd, input logic wr);
    bus.ThreadQ103H  = th;
    bus.AddressQ103H = addr;
    bus.WrDataQ103H  = wd;
    bus.RdEnQ103H    = rd;
    bus.WrEnQ103H    = wr;
    bus.RemoteQ103H  = 1'b1;
  endtask

  task automatic send_rsp(input logic [1:0] tid, input logic [31:0] d);
    bus.C2F_RspValidQ502H    = 1'b1;
    bus.C2F_RspThreadIDQ502H = tid;
    bus.C2F_RspDataQ502H     = d;
    tick();
    clear_rsp();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (bus.C2F_ReqValidQ500H !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.C2F_ReqValidQ500H); end
    n_checks++; if (bus.C2F_ReqAddressQ500H !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %08h want 0", bus.C2F_ReqAddressQ500H); end
    n_checks++; if (bus.ThreadFreeze !== 4'h0) begin n_fail++; $display("FAIL reset_freeze got %b want 0000", bus.ThreadFreeze); end
    n_checks++; if (bus.C2F_RspMatchQ104H !== 1'b0) begin n_fail++; $display("FAIL reset_match got %0b want 0", bus.C2F_RspMatchQ104H); end
    n_checks++; if (bus.TimeoutErr !== 4'h0) begin n_fail++; $display("FAIL reset_tout got %b want 0000", bus.TimeoutErr); end
    n_checks++; if (bus.SpurRspErr !== 1'b0) begin n_fail++; $display("FAIL reset_spur got %0b want 0", bus.SpurRspErr); end
  endtask

  task automatic test_single_read();
    drive_access(4'b0001, 32'h0200_1004, 32'h0, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.ThreadFreeze !== 4'b0001) begin n_fail++; $display("FAIL t1_freeze_capture got %b want 0001", bus.ThreadFreeze); end
    tick();
    clear_core();
    n_checks++; if (bus.C2F_ReqValidQ500H !== 1'b0) begin n_fail++; $display("FAIL t1_valid_early got %0b want 0", bus.C2F_ReqValidQ500H); end
    tick();
    n_checks++; if (bus.C2F_ReqValidQ500H !== 1'b1) begin n_fail++; $display("FAIL t1_valid got %0b want 1", bus.C2F_ReqValidQ500H); end
    n_checks++; if (bus.C2F_ReqOpcodeQ500H !== OP_RD) begin n_fail++; $display("FAIL t1_opcode got %0d want RD", bus.C2F_ReqOpcodeQ500H); end
    n_checks++; if (bus.C2F_ReqThreadIDQ500H !== 2'd0) begin n_fail++; $display("FAIL t1_tid got %0d want 0", bus.C2F_ReqThreadIDQ500H); end
    n_checks++; if (bus.C2F_ReqAddressQ500H !== 32'h0200_1004) begin n_fail++; $display("FAIL t1_addr got %08h want 02001004", bus.C2F_ReqAddressQ500H); end
    n_checks++; if (bus.ThreadFreeze !== 4'b0001) begin n_fail++; $display("FAIL t1_freeze_wait got %b want 0001", bus.ThreadFreeze); end
    tick();
    n_checks++; if (bus.C2F_ReqValidQ500H !== 1'b0) begin n_fail++; $display("FAIL t1_valid_pulse got %0b want 0", bus.C2F_ReqValidQ500H); end
    n_checks++; if (bus.C2F_ReqAddressQ500H !== 32'h0) begin n_fail++; $display("FAIL t1_addr_idle got %08h want 0", bus.C2F_ReqAddressQ500H); end
    send_rsp(2'd0, 32'h1234_5678);
    n_checks++; if (bus.ThreadFreeze !== 4'b0000) begin n_fail++; $display("FAIL t1_freeze_done got %b want 0000", bus.ThreadFreeze); end
    n_checks++; if (bus.C2F_RspMatchQ104H !== 1'b0) begin n_fail++; $display("FAIL t1_match_early got %0b want 0", bus.C2F_RspMatchQ104H); end
    bus.ThreadQ103H = 4'b0001;
    tick();
    clear_core();
    n_checks++; if (bus.C2F_RspMatchQ104H !== 1'b1) begin n_fail++; $display("FAIL t1_match got %0b want 1", bus.C2F_RspMatchQ104H); end
    n_checks++; if (bus.C2F_RspDataQ104H !== 32'h1234_5678) begin n_fail++; $display("FAIL t1_rdata got %08h want 12345678", bus.C2F_RspDataQ104H); end
    tick();
    n_checks++; if (bus.C2F_RspMatchQ104H !== 1'b0) begin n_fail++; $display("FAIL t1_match_pulse got %0b want 0", bus.C2F_RspMatchQ104H); end
    n_checks++; if (bus.SpurRspErr !== 1'b0) begin n_fail++; $display("FAIL t1_spur got %0b want 0", bus.SpurRspErr); end
  endtask

  task automatic test_write_stall();
    bus.C2F_RspStall = 1'b1;
    drive_access(4'b0100, 32'h0300_0008, 32'hCAFE_F00D, 1'b0, 1'b1);
    tick();
    clear_core();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.C2F_ReqValidQ500H !== 1'b0) begin n_fail++; $display("FAIL t2_stall_valid[%0d] got %0b want 0", i, bus.C2F_ReqValidQ500H); end
      n_checks++; if (bus.ThreadFreeze !== 4'b0100) begin n_fail++; $display("FAIL t2_stall_freeze[%0d] got %b want 0100", i, bus.ThreadFreeze); end
      if (i < 4) tick();
    end
    bus.C2F_RspStall = 1'b0;
    tick();
    n_checks++; if (bus.C2F_ReqValidQ500H !== 1'b1) begin n_fail++; $display("FAIL t2_valid got %0b want 1", bus.C2F_ReqValidQ500H); end
    n_checks++; if (bus.C2F_ReqOpcodeQ500H !== OP_WR) begin n_fail++; $display("FAIL t2_opcode got %0d want WR", bus.C2F_ReqOpcodeQ500H); end
    n_checks++; if (bus.C2F_ReqThreadIDQ500H !== 2'd2) begin n_fail++; $display("FAIL t2_tid got %0d want 2", bus.C2F_ReqThreadIDQ500H); end
    n_checks++; if (bus.C2F_ReqAddressQ500H !== 32'h0300_0008) begin n_fail++; $display("FAIL t2_addr got %08h want 03000008", bus.C2F_ReqAddressQ500H); end
    n_checks++; if (bus.C2F_ReqDataQ500H !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL t2_data got %08h want cafef00d", bus.C2F_ReqDataQ500H); end
    n_checks++; if (bus.ThreadFreeze !== 4'b0000) begin n_fail++; $display("FAIL t2_freeze got %b want 0000", bus.ThreadFreeze); end
    tick();
    n_checks++; if (bus.C2F_ReqValidQ500H !== 1'b0) begin n_fail++; $display("FAIL t2_valid_pulse got %0b want 0", bus.C2F_ReqValidQ500H); end
  endtask

  task automatic test_four_reads();
    logic [1:0]  rsp_order [4];
    logic [31:0] exp_data;
    rsp_order[0] = 2'd3; rsp_order[1] = 2'd1; rsp_order[2] = 2'd0; rsp_order[3] = 2'd2;
    for (int i = 0; i < 4; i++) begin
      drive_access(4'b0001 << i, 32'h1000_0000 + 32'(i * 4), 32'h0, 1'b1, 1'b0);
      tick();
      if (i > 0) begin
        n_checks++; if (bus.C2F_ReqValidQ500H !== 1'b1 || bus.C2F_ReqThreadIDQ500H !== 2'(i - 1)) begin
          n_fail++; $display("FAIL t3_issue[%0d] got v=%0b tid=%0d want v=1 tid=%0d", i - 1, bus.C2F_ReqValidQ500H, bus.C2F_ReqThreadIDQ500H, i - 1); end
      end
    end
    clear_core();
    tick();
    n_checks++; if (bus.C2F_ReqValidQ500H !== 1'b1 || bus.C2F_ReqThreadIDQ500H !== 2'd3 || bus.C2F_ReqAddressQ500H !== 32'h1000_000C) begin
      n_fail++; $display("FAIL t3_issue[3] got v=%0b tid=%0d addr=%08h want v=1 tid=3 addr=1000000c", bus.C2F_ReqValidQ500H, bus.C2F_ReqThreadIDQ500H, bus.C2F_ReqAddressQ500H); end
    n_checks++; if (bus.ThreadFreeze !== 4'b1111) begin n_fail++; $display("FAIL t3_freeze_all got %b want 1111", bus.ThreadFreeze); end
    for (int i = 0; i < 4; i++) send_rsp(rsp_order[i], 32'hA000_0000 | 32'(rsp_order[i]));
    n_checks++; if (bus.ThreadFreeze !== 4'b0000) begin n_fail++; $display("FAIL t3_freeze_done got %b want 0000", bus.ThreadFreeze); end
    for (int t = 0; t < 4; t++) begin
      bus.ThreadQ103H = 4'b0001 << t;
      tick();
      exp_data = 32'hA000_0000 | 32'(t);
      n_checks++; if (bus.C2F_RspMatchQ104H !== 1'b1 || bus.C2F_RspDataQ104H !== exp_data) begin
        n_fail++; $display("FAIL t3_replay[%0d] got m=%0b d=%08h want m=1 d=%08h", t, bus.C2F_RspMatchQ104H, bus.C2F_RspDataQ104H, exp_data); end
    end
    clear_core();
    tick();
    n_checks++; if (bus.SpurRspErr !== 1'b0) begin n_fail++; $display("FAIL t3_spur got %0b want 0", bus.SpurRspErr); end
  endtask

  task automatic test_timeout();
    // Case 1: thread 1 never gets a response.
    drive_access(4'b0010, 32'h0400_0000, 32'h0, 1'b1, 1'b0);
    tick();
    clear_core();
    tick();
    n_checks++; if (bus.C2F_ReqValidQ500H !== 1'b1 || bus.C2F_ReqThreadIDQ500H !== 2'd1) begin
      n_fail++; $display("FAIL t4_issue got v=%0b tid=%0d want v=1 tid=1", bus.C2F_ReqValidQ500H, bus.C2F_ReqThreadIDQ500H); end
    for (int i = 0; i < 1023; i++) tick();
    n_checks++; if (bus.ThreadFreeze !== 4'b0010 || bus.TimeoutErr !== 4'b0000) begin
      n_fail++; $display("FAIL t4_before_expiry got frz=%b to=%b want frz=0010 to=0000", bus.ThreadFreeze, bus.TimeoutErr); end
    tick();
    n_checks++; if (bus.TimeoutErr !== 4'b0010) begin n_fail++; $display("FAIL t4_tout got %b want 0010", bus.TimeoutErr); end
    n_checks++; if (bus.ThreadFreeze !== 4'b0000) begin n_fail++; $display("FAIL t4_freeze got %b want 0000", bus.ThreadFreeze); end
    bus.ThreadQ103H = 4'b0010;
    tick();
    clear_core();
    n_checks++; if (bus.C2F_RspMatchQ104H !== 1'b1 || bus.C2F_RspDataQ104H !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL t4_to_data got m=%0b d=%08h want m=1 d=deadbeef", bus.C2F_RspMatchQ104H, bus.C2F_RspDataQ104H); end
    // Case 2: thread 3 response lands exactly on the expiry cycle.
    drive_access(4'b1000, 32'h0400_0010, 32'h0, 1'b1, 1'b0);
    tick();
    clear_core();
    tick();
    for (int i = 0; i < 1023; i++) tick();
    send_rsp(2'd3, 32'h5555_AAAA);
    n_checks++; if (bus.TimeoutErr !== 4'b0010) begin n_fail++; $display("FAIL t4_race_tout got %b want 0010", bus.TimeoutErr); end
    n_checks++; if (bus.ThreadFreeze !== 4'b0000) begin n_fail++; $display("FAIL t4_race_freeze got %b want 0000", bus.ThreadFreeze); end
    bus.ThreadQ103H = 4'b1000;
    tick();
    clear_core();
    n_checks++; if (bus.C2F_RspMatchQ104H !== 1'b1 || bus.C2F_RspDataQ104H !== 32'h5555_AAAA) begin
      n_fail++; $display("FAIL t4_race_data got m=%0b d=%08h want m=1 d=5555aaaa", bus.C2F_RspMatchQ104H, bus.C2F_RspDataQ104H); end
    n_checks++; if (bus.SpurRspErr !== 1'b0) begin n_fail++; $display("FAIL t4_spur got %0b want 0", bus.SpurRspErr); end
    tick();
  endtask

  task automatic test_spurious_reset();
    send_rsp(2'd1, 32'h0BAD_0001);
    n_checks++; if (bus.SpurRspErr !== 1'b1) begin n_fail++; $display("FAIL t5_spur got %0b want 1", bus.SpurRspErr); end
    n_checks++; if (bus.ThreadFreeze !== 4'b0000 || bus.C2F_RspMatchQ104H !== 1'b0) begin
      n_fail++; $display("FAIL t5_no_change got frz=%b m=%0b want frz=0000 m=0", bus.ThreadFreeze, bus.C2F_RspMatchQ104H); end
    drive_access(4'b0001, 32'h0500_0000, 32'h0, 1'b1, 1'b0);
    tick();
    clear_core();
    tick();
    n_checks++; if (bus.ThreadFreeze !== 4'b0001 || bus.C2F_ReqValidQ500H !== 1'b1) begin
      n_fail++; $display("FAIL t5_wait got frz=%b v=%0b want frz=0001 v=1", bus.ThreadFreeze, bus.C2F_ReqValidQ500H); end
    rst = 1'b1;
    tick();
    n_checks++; if (bus.ThreadFreeze !== 4'b0000 || bus.C2F_ReqValidQ500H !== 1'b0 || bus.SpurRspErr !== 1'b0 ||
                    bus.TimeoutErr !== 4'b0000 || bus.C2F_RspMatchQ104H !== 1'b0 || bus.C2F_ReqAddressQ500H !== 32'h0) begin
      n_fail++; $display("FAIL t5_reset_outputs got frz=%b v=%0b spur=%0b to=%b m=%0b addr=%08h want all 0",
                         bus.ThreadFreeze, bus.C2F_ReqValidQ500H, bus.SpurRspErr, bus.TimeoutErr, bus.C2F_RspMatchQ104H, bus.C2F_ReqAddressQ500H); end
    rst = 1'b0;
    send_rsp(2'd0, 32'h7777_0000);
    n_checks++; if (bus.SpurRspErr !== 1'b1) begin n_fail++; $display("FAIL t5_post_reset_spur got %0b want 1", bus.SpurRspErr); end
    n_checks++; if (bus.ThreadFreeze !== 4'b0000) begin n_fail++; $display("FAIL t5_post_reset_freeze got %b want 0000", bus.ThreadFreeze); end
    bus.ThreadQ103H = 4'b0001;
    tick();
    clear_core();
    n_checks++; if (bus.C2F_RspMatchQ104H !== 1'b0) begin n_fail++; $display("FAIL t5_no_replay got %0b want 0", bus.C2F_RspMatchQ104H); end
  endtask

  initial begin
    clear_core();
    clear_rsp();
    bus.C2F_RspStall = 1'b0;
    test_reset();
    test_single_read();
    test_write_stall();
    test_four_reads();
    test_timeout();
    test_spurious_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
